// File: rtl/ext_int_ctrl_if.sv
// rtl/ext_int_ctrl_if.sv - register access port of the external interrupt conditioner
interface ext_int_ctrl_if;
   logic        start;
   logic        we;
   logic [1:0]  addr;
   logic [31:0] data;
   logic [31:0] q;
   logic        done;

   modport master (output start, we, addr, data, input q, done);
   modport slave  (input start, we, addr, data, output q, done);
endinterface

// File: rtl/ext_int_ctrl.sv
// rtl/ext_int_ctrl.sv - sync, debounce and falling-edge detect for four active-low interrupt pins
module ext_int_ctrl #(
   parameter int DEBOUNCE_CYCLES = 250,
   parameter int CNT_W           = 8
) (
   input  logic           clk,
   input  logic           reset,
   input  logic [3:0]     nint,
   output logic [3:0]     int_out,
   ext_int_ctrl_if.slave  bus
);

   // 0 and 1 both mean "accept a change after one stable cycle"
   localparam int N = (DEBOUNCE_CYCLES < 1) ? 1 : DEBOUNCE_CYCLES;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

   logic [3:0]       s1, s2;
   logic [3:0]       st, st_d;
   logic [CNT_W-1:0] cnt [4];
   logic [3:0]       mask, pending;
   logic [3:0]       fall;
   logic [3:0]       w1c;
   logic             acc_v;
   logic [1:0]       acc_addr;
   logic [31:0]      rd_val;
   logic             unused_data;

   assign unused_data = ^bus.data[31:4];

   // Qualified falling edge of the debounced level; this is both the pulse and the pending set
   assign fall = st_d & ~st & mask;

   // Write-1-to-clear strobe for the pending register
   assign w1c = (bus.start && bus.we && bus.addr == 2'd1) ? bus.data[3:0] : 4'h0;

   // Two-flop synchroniser, idle level high so a released pin reads as inactive
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 4'hF;
         s2 <= 4'hF;
      end else begin
         s1 <= nint;
         s2 <= s1;
      end
   end

   // Debounce: a level change is accepted only after N consecutive deviating samples
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st <= 4'hF;
         for (int i = 0; i < 4; i++) cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (s2[i] == st[i]) begin
               cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
               st[i]  <= s2[i];
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end
         end
      end
   end

   // Edge detector output and sticky pending flags; a new edge wins over a same-cycle clear
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_d    <= 4'hF;
         int_out <= 4'h0;
         pending <= 4'h0;
      end else begin
         st_d    <= st;
         int_out <= fall;
         pending <= (pending & ~w1c) | fall;
      end
   end

   // Mask register; the new value only qualifies edges after the write edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mask <= 4'hF;
      end else if (bus.start && bus.we && bus.addr == 2'd0) begin
         mask <= bus.data[3:0];
      end
   end

   // Read mux, evaluated one cycle after the access so writes are reflected
   always_comb begin
      rd_val = 32'h0;
      case (acc_addr)
         2'd0:    rd_val = {28'h0, mask};
         2'd1:    rd_val = {28'h0, pending};
         2'd2:    rd_val = {28'h0, ~st};
         default: rd_val = 32'h0;
      endcase
   end

   // Access pipeline: capture at the start edge, complete with done and q one edge later
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_v    <= 1'b0;
         acc_addr <= 2'd0;
         bus.done <= 1'b0;
         bus.q    <= 32'h0;
      end else begin
         acc_v    <= bus.start;
         acc_addr <= bus.addr;
         bus.done <= acc_v;
         if (acc_v) bus.q <= rd_val;
      end
   end

endmodule

// File: doc/ext_int_ctrl.md
Name: ext_int_ctrl

Overview:
- Conditions the four active-low external interrupt pins (nint1..nint4) so the CPU can use them.
- Each line is synchronised, debounced and falling-edge detected. A qualified edge produces a one-clock interrupt pulse to the CPU and sets a sticky pending bit.
- A small register port on the MemoryUnit side gives software a mask, write-1-to-clear pending flags and the debounced pin levels.
- Sits between the top-level pins and the CPU int inputs, clocked by the 25 MHz clk domain.

Parameters:
- DEBOUNCE_CYCLES, 250, consecutive stable cycles needed to accept a level change (10 us at 25 MHz). Values 0 and 1 both mean 1.
- CNT_W, 8, debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock (25 MHz PLL output)
- reset  in  1  asynchronous, active-high reset
- nint  in  4  raw external interrupt pins, active low, asynchronous; bit0 = nint1
- int_out  out  4  one-cycle interrupt pulses to CPU int1..int4 selection
- start  in  1  register access strobe, one cycle
- we  in  1  write enable, sampled with start
- addr  in  2  register select, sampled with start
- data  in  32  write data, sampled with start
- q  out  32  read data
- done  out  1  access complete, one-cycle pulse

Behaviour:
- Reset values: int_out=0, q=0, done=0, mask=4'hF, pending=0, both synchroniser flops=1, stable level st=1, counters=0.
- Reset is asynchronous assert, and releases on the next clk edge. Any access in flight is dropped (done is not issued).
- Synchroniser: per line, two flops, s1<=nint, s2<=s1.
- Debounce, per line, with N = max(DEBOUNCE_CYCLES,1):
  - If s2==st: cnt<=0.
  - Else if cnt==N-1: st<=s2 and cnt<=0.
  - Else: cnt<=cnt+1.
  - A deviation shorter than N consecutive cycles never changes st. The counter restarts on any return to st.
- Edge detect: st_d<=st, then int_out[i]<=st_d[i] & ~st[i] & mask[i]. The pulse is exactly one cycle.
  - Rising edges (release of the pin) produce no pulse.
- Latency: pin first sampled low at rising edge E0 and held low gives int_out high from edge E0+N+2 to E0+N+3.
- Pending: pending[i] is set in the same edge that int_out[i] is set, so masked edges never set it.
  - A set and a W1C on the same edge leaves the bit set.
- Mask clear does not alter existing pending bits. A mask write takes effect on edges after the write edge.
- Pin low at reset release: st restarts at 1, so a pin held low produces one qualified falling edge (pulse plus pending) N+2 edges after release, if unmasked.
- All four lines are independent. Simultaneous edges on several lines produce simultaneous pulses. There is no priority logic.
- Register map, addr:
  - 0 MASK: rw, bits[3:0], upper bits read 0.
  - 1 PENDING: read bits[3:0]; writing 1 clears the bit, writing 0 has no effect.
  - 2 LEVEL: ro, ~st[3:0], so 1 = asserted. Writes are ignored.
  - 3 reserved: reads 0, writes ignored.
- Access handshake:
  - start is sampled at edge A. The write (if we) is performed at edge A.
  - done=1 and q valid from edge A+1 for one cycle. q then holds its value until the next read completes.
  - A write returns q = the register value after the write.
  - start may be asserted every cycle. Back-to-back accesses complete back-to-back.
  - start while done=1 is legal.

Test Plan:
- N=4, mask=F, nint[0] driven low at edge 10 and held -> int_out=4'b0001 for exactly one cycle (edges 16-17); PENDING read = 0x1; LEVEL read = 0x1.
- N=4, nint[2] low for 3 cycles then high (glitch) -> int_out stays 0; PENDING = 0; LEVEL = 0.
- Write MASK=0x0 (start, we, addr=0, data=0), then nint[1] falls and settles -> no pulse; PENDING = 0; MASK read = 0x0; done pulses one cycle after each start.
- PENDING = 0xF after falls on all lines; write addr=1 data=0x5 -> PENDING read = 0xA. Repeat the W1C of bit 3 on the same edge that a new line-3 pulse is set -> bit 3 remains 1.
- All four pins falling in the same cycle -> int_out = 4'hF for one cycle. Pins released -> no pulse, LEVEL returns to 0.
- nint[3] held low through reset release, N=4 -> pulse on int_out[3] at the 6th edge after release. Assert reset mid-debounce on another line -> counters clear and no pulse for that line.
